// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the obstacle-dodge game
//                sequencer: game state encoding, LFSR seed/taps and the
//                score interval that triggers a speed-up.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Encoded values are visible on the state output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form: taps on bits 7,5,4,3.
    localparam logic [7:0] c_lfsr_seed = 8'h01;
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    // Every this many points the step period shortens (speed-up builds only).
    localparam int unsigned c_speedup_interval = 8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & c_lfsr_taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer_if
//  Description : Control inputs and game outputs of the sequencer.
//                master : the controller side (drives start/pause/buttons)
//                slave  : the sequencer (drives positions, score, status)
//  Signals     : start, pause, btn_up, btn_down  -> sequencer
//                obstacle_x/y, player_x/y, score, game_over, state, step
//                                                 <- sequencer
//  Revision    : 1.0  initial release
// ============================================================================
interface game_sequencer_if
    import game_pkg::*;
#(
    parameter int unsigned X_W     = 4,
    parameter int unsigned Y_W     = 2,
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic               pause;
    logic               btn_up;
    logic               btn_down;
    logic [X_W-1:0]     obstacle_x;
    logic [Y_W-1:0]     obstacle_y;
    logic [X_W-1:0]     player_x;
    logic [Y_W-1:0]     player_y;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    game_state_t        state;
    logic               step;

    modport master (
        output start, pause, btn_up, btn_down,
        input  obstacle_x, obstacle_y, player_x, player_y,
               score, game_over, state, step
    );

    modport slave (
        input  start, pause, btn_up, btn_down,
        output obstacle_x, obstacle_y, player_x, player_y,
               score, game_over, state, step
    );
endinterface
`default_nettype wire

// File: rtl/game_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : game_lfsr
//  Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick the
//                lane of each new obstacle.
//  Ports       : clock   - clock
//                reset   - asynchronous active-low reset (loads seed 8'h01)
//                advance - shift one position this cycle
//                value   - current register contents
//  Revision    : 1.0  initial release
// ============================================================================
module game_lfsr
    import game_pkg::*;
(
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       advance,
    output logic [7:0]      value
);
    logic [7:0] r_value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= c_lfsr_seed;
        end else if (advance) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Game state machine, movement time base, obstacle spawning,
//                player lane control and scoring for the obstacle-dodge game.
//                All outputs are registered.
//  Ports       : clock - clock
//                reset - asynchronous active-low reset
//                bus   - game_sequencer_if.slave (controls in, game state out)
//  Options     : GAME_SPEEDUP_EN - when defined, the step period shrinks by
//                DIV_STEP (floored at MIN_DIV) every 8 points; otherwise it
//                stays at TICK_DIV.
//  Revision    : 1.0  initial release
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned X_W      = 4,
    parameter int unsigned Y_W      = 2,
    parameter int unsigned PLAYER_X = 2,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned MIN_DIV  = 200,
    parameter int unsigned DIV_STEP = 100
)(
    input  wire logic          clock,
    input  wire logic          reset,
    game_sequencer_if.slave    bus
);
    // The period register must be able to hold the larger of the start
    // period and the speed-up floor.
    localparam int unsigned c_div_max = (TICK_DIV > MIN_DIV) ? TICK_DIV : MIN_DIV;
    localparam int unsigned DIV_W     = $clog2(c_div_max + 1);

    localparam logic [X_W-1:0]   c_player_x = X_W'(PLAYER_X);
    localparam logic [DIV_W-1:0] c_tick_div = DIV_W'(TICK_DIV);

    game_state_t        r_state,      w_state_nxt;
    logic [DIV_W-1:0]   r_div,        w_div_nxt;
    logic [DIV_W-1:0]   r_period,     w_period_nxt;
    logic [X_W-1:0]     r_obs_x,      w_obs_x_nxt;
    logic [Y_W-1:0]     r_obs_y,      w_obs_y_nxt;
    logic [Y_W-1:0]     r_player_y,   w_player_y_nxt;
    logic [SCORE_W-1:0] r_score,      w_score_nxt;
    logic               r_game_over,  w_game_over_nxt;
    logic               r_step,       w_step_nxt;
    logic [SCORE_W-1:0] w_score_inc;
    logic               w_collide;
    logic               w_init;
    logic [7:0]         w_lfsr;

    // The LFSR runs on every RUN cycle, including the cycle that collides
    // or requests a pause.
    game_lfsr u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (r_state == RUN),
        .value   (w_lfsr)
    );

    assign w_collide   = (r_obs_x == c_player_x) && (r_obs_y == r_player_y);
    assign w_score_inc = r_score + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_period_nxt    = r_period;
        w_obs_x_nxt     = r_obs_x;
        w_obs_y_nxt     = r_obs_y;
        w_player_y_nxt  = r_player_y;
        w_score_nxt     = r_score;
        w_game_over_nxt = r_game_over;
        w_step_nxt      = 1'b0;
        w_init          = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_init = 1'b1;
                end
            end

            RUN: begin
                if (w_collide) begin
                    // Collision wins: the step and buttons of this cycle are dropped.
                    w_state_nxt     = OVER;
                    w_game_over_nxt = 1'b1;
                end else begin
                    if (bus.pause) begin
                        w_state_nxt = PAUSE;
                    end else begin
                        // '>=' lets the count wrap cleanly right after the
                        // period has been shortened mid-count.
                        w_div_nxt = (r_div >= r_period - 1'b1) ? '0 : r_div + 1'b1;
                        // step is registered, so it is raised one cycle early:
                        // it is high while the divider sits on its terminal count.
                        if (w_div_nxt == r_period - 1'b1) begin
                            w_step_nxt = 1'b1;
                            if (r_obs_x == '0) begin
                                w_obs_x_nxt = '1;
                                w_obs_y_nxt = w_lfsr[Y_W-1:0];
                            end else begin
                                w_obs_x_nxt = r_obs_x - 1'b1;
                            end
                            // Leaving the player column without colliding is a pass.
                            if (r_obs_x == c_player_x && r_score != '1) begin
                                w_score_nxt = w_score_inc;
`ifdef GAME_SPEEDUP_EN
                                if ((32'(w_score_inc) % c_speedup_interval) == 0) begin
                                    if (32'(r_period) >= MIN_DIV + DIV_STEP) begin
                                        w_period_nxt = r_period - DIV_W'(DIV_STEP);
                                    end else begin
                                        w_period_nxt = DIV_W'(MIN_DIV);
                                    end
                                end
`endif
                            end
                        end
                    end

                    if (bus.btn_up && !bus.btn_down && r_player_y != '1) begin
                        w_player_y_nxt = r_player_y + 1'b1;
                    end else if (bus.btn_down && !bus.btn_up && r_player_y != '0) begin
                        w_player_y_nxt = r_player_y - 1'b1;
                    end
                end
            end

            PAUSE: begin
                if (bus.start) begin
                    w_init = 1'b1;
                end else if (bus.pause) begin
                    w_state_nxt = RUN;
                end
            end

            OVER: begin
                if (bus.start) begin
                    w_init = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // New game: everything except the LFSR returns to its reset value.
        if (w_init) begin
            w_state_nxt     = RUN;
            w_div_nxt       = '0;
            w_period_nxt    = c_tick_div;
            w_obs_x_nxt     = '1;
            w_obs_y_nxt     = '0;
            w_player_y_nxt  = '0;
            w_score_nxt     = '0;
            w_game_over_nxt = 1'b0;
            w_step_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_period    <= c_tick_div;
            r_obs_x     <= '1;
            r_obs_y     <= '0;
            r_player_y  <= '0;
            r_score     <= '0;
            r_game_over <= 1'b0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_period    <= w_period_nxt;
            r_obs_x     <= w_obs_x_nxt;
            r_obs_y     <= w_obs_y_nxt;
            r_player_y  <= w_player_y_nxt;
            r_score     <= w_score_nxt;
            r_game_over <= w_game_over_nxt;
            r_step      <= w_step_nxt;
        end
    end

    assign bus.obstacle_x = r_obs_x;
    assign bus.obstacle_y = r_obs_y;
    assign bus.player_x   = c_player_x;
    assign bus.player_y   = r_player_y;
    assign bus.score      = r_score;
    assign bus.game_over  = r_game_over;
    assign bus.state      = r_state;
    assign bus.step       = r_step;

endmodule
`default_nettype wire
